mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter_mux.sv | 40 ++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the two-requester memory arbiter.
//   state_t - arbiter FSM states (IDLE / REQ / RESP)
//   owner_t - which requester owns the memory port (OWN_INST / OWN_DATA)
//   size_t  - request size field encoding (byte / half / word)
//   pick_owner() - fixed-priority grant with starvation override
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    // Data wins unless inst is waiting and has hit the starvation limit.
    // Only meaningful when at least one request is present.
    function automatic owner_t pick_owner(input logic i_req, input logic d_req,
                                          input logic starved);
        if (d_req && !(i_req && starved))
            return OWN_DATA;
        else
            return OWN_INST;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one request/response bus (SRAM-like handshake).
//   req/wr/size/wstrb/addr/wdata - request fields, driven by the master
//   addr_ok                     - request accepted, driven by the slave
//   data_ok/rdata               - response (read data or write ack), slave
// modport master: the side issuing requests; modport slave: the side serving.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_arbiter_mux.sv
// mem_arb_mux: combinational owner-select mux for the shared request fields.
//   owner          - current owner of the memory port
//   i_* / d_*      - live request fields of inst and data requesters
//   sel_*          - the owner's request fields (sel_req is ungated)
module mem_arb_mux
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  owner_t            owner,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [3:0]        i_wstrb,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              sel_req,
    output logic              sel_wr,
    output logic [1:0]        sel_size,
    output logic [3:0]        sel_wstrb,
    output logic [ADDR_W-1:0] sel_addr,
    output logic [DATA_W-1:0] sel_wdata
);
    logic is_inst;
    assign is_inst = (owner == OWN_INST);

    assign sel_req   = is_inst ? i_req   : d_req;
    assign sel_wr    = is_inst ? i_wr    : d_wr;
    assign sel_size  = is_inst ? i_size  : d_size;
    assign sel_wstrb = is_inst ? i_wstrb : d_wstrb;
    assign sel_addr  = is_inst ? i_addr  : d_addr;
    assign sel_wdata = is_inst ? i_wdata : d_wdata;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction and a data requester onto one
// memory port, one outstanding transaction at a time.
//   clk, rst  - clock and synchronous active-high reset
//   i_cancel  - pipeline flush; any outstanding inst response is discarded
//   inst      - inst requester bus (slave side)
//   data      - data requester bus (slave side)
//   mem       - shared memory bus (master side)
// Data has priority; inst is forced through after STARVE_LIM consecutive
// data grants while it waits.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cancel,
    mem_arbiter_if.slave    inst,
    mem_arbiter_if.slave    data,
    mem_arbiter_if.master   mem
);
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             discard;

    logic              sel_req;
    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [3:0]        sel_wstrb;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    mem_arb_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .owner     (owner),
        .i_req     (inst.req),
        .i_wr      (inst.wr),
        .i_size    (inst.size),
        .i_wstrb   (inst.wstrb),
        .i_addr    (inst.addr),
        .i_wdata   (inst.wdata),
        .d_req     (data.req),
        .d_wr      (data.wr),
        .d_size    (data.size),
        .d_wstrb   (data.wstrb),
        .d_addr    (data.addr),
        .d_wdata   (data.wdata),
        .sel_req   (sel_req),
        .sel_wr    (sel_wr),
        .sel_size  (sel_size),
        .sel_wstrb (sel_wstrb),
        .sel_addr  (sel_addr),
        .sel_wdata (sel_wdata)
    );

    owner_t grant;
    logic   inst_cancel;
    logic   in_req;
    logic   in_resp;
    logic   m_req;
    logic   addr_hs;
    logic   drop_resp;

    assign grant       = pick_owner(inst.req, data.req, starve_cnt == LIM);
    assign inst_cancel = i_cancel && (owner == OWN_INST);

    // Handshakes are combinational decodes of the registered state so that
    // addr_ok/data_ok land in the same cycle as the memory's handshake.
    assign in_req    = !rst && (state == S_REQ);
    assign in_resp   = !rst && (state == S_RESP);
    assign m_req     = in_req && sel_req;
    assign addr_hs   = m_req && mem.addr_ok;
    // A cancel in the completing cycle suppresses the response as well.
    assign drop_resp = discard || inst_cancel;

    assign mem.req   = m_req;
    assign mem.wr    = sel_wr;
    assign mem.size  = sel_size;
    assign mem.wstrb = sel_wstrb;
    assign mem.addr  = sel_addr;
    assign mem.wdata = sel_wdata;

    assign inst.addr_ok = addr_hs && (owner == OWN_INST);
    assign data.addr_ok = addr_hs && (owner == OWN_DATA);
    assign inst.data_ok = in_resp && mem.data_ok && (owner == OWN_INST) && !drop_resp;
    assign data.data_ok = in_resp && mem.data_ok && (owner == OWN_DATA);
    assign inst.rdata   = (!rst && owner == OWN_INST) ? mem.rdata : '0;
    assign data.rdata   = (!rst && owner == OWN_DATA) ? mem.rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_DATA;
            starve_cnt <= '0;
            discard    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inst.req || data.req) begin
                        owner <= grant;
                        state <= S_REQ;
                        if (grant == OWN_INST || !inst.req)
                            starve_cnt <= '0;
                        else if (starve_cnt != LIM)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    if (!sel_req) begin
                        state <= S_IDLE;
                    end else if (mem.addr_ok) begin
                        state <= S_RESP;
                        if (inst_cancel)
                            discard <= 1'b1;
                    end else if (inst_cancel) begin
                        state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (mem.data_ok) begin
                        state   <= S_IDLE;
                        discard <= 1'b0;
                    end else if (inst_cancel) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_cancel = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_cancel (i_cancel),
        .inst     (inst_if),
        .data     (data_if),
        .mem      (mem_if)
    );

    task automatic idle_inputs();
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.wstrb = 4'h0;
        inst_if.addr = '0; inst_if.wdata = '0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.wstrb = 4'h0;
        data_if.addr = '0; data_if.wdata = '0;
        mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = '0;
        i_cancel = 0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        inst_if.req = 1; data_if.req = 1;
        mem_if.addr_ok = 1; mem_if.data_ok = 1; mem_if.rdata = 32'hCAFEF00D;
        to_next();
        to_neg();
        vectors++; if (mem_if.req !== 1'b0) begin miscompares++; $display("FAIL rst_m_req: got %b want 0", mem_if.req); end
        vectors++; if (inst_if.addr_ok !== 1'b0) begin miscompares++; $display("FAIL rst_i_addr_ok: got %b want 0", inst_if.addr_ok); end
        vectors++; if (data_if.addr_ok !== 1'b0) begin miscompares++; $display("FAIL rst_d_addr_ok: got %b want 0", data_if.addr_ok); end
        vectors++; if (inst_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_i_data_ok: got %b want 0", inst_if.data_ok); end
        vectors++; if (data_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_d_data_ok: got %b want 0", data_if.data_ok); end
        vectors++; if (inst_if.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_i_rdata: got %h want 0", inst_if.rdata); end
        vectors++; if (data_if.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_d_rdata: got %h want 0", data_if.rdata); end
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
        vectors++; if (dut.owner !== OWN_DATA) begin miscompares++; $display("FAIL rst_owner: got %0d want DATA", dut.owner); end
        vectors++; if (dut.starve_cnt !== '0) begin miscompares++; $display("FAIL rst_starve: got %0d want 0", dut.starve_cnt); end
        vectors++; if (dut.discard !== 1'b0) begin miscompares++; $display("FAIL rst_discard: got %b want 0", dut.discard); end
        to_next();
        idle_inputs();
        rst = 0;
        to_next();
    endtask

    task automatic test_single_read();
        inst_if.req = 1; inst_if.addr = 32'h1C000000;
        to_neg();
        vectors++; if (mem_if.req !== 1'b0) begin miscompares++; $display("FAIL rd_idle_m_req: got %b want 0", mem_if.req); end
        to_next();
        mem_if.addr_ok = 1;
        to_neg();
        vectors++; if (mem_if.req !== 1'b1) begin miscompares++; $display("FAIL rd_m_req: got %b want 1", mem_if.req); end
        vectors++; if (mem_if.addr !== 32'h1C000000) begin miscompares++; $display("FAIL rd_m_addr: got %h want 1c000000", mem_if.addr); end
        vectors++; if (mem_if.wr !== 1'b0) begin miscompares++; $display("FAIL rd_m_wr: got %b want 0", mem_if.wr); end
        vectors++; if (inst_if.addr_ok !== 1'b1) begin miscompares++; $display("FAIL rd_i_addr_ok: got %b want 1", inst_if.addr_ok); end
        vectors++; if (data_if.addr_ok !== 1'b0) begin miscompares++; $display("FAIL rd_d_addr_ok: got %b want 0", data_if.addr_ok); end
        to_next();
        inst_if.req = 0; mem_if.addr_ok = 0;
        to_neg();
        vectors++; if (mem_if.req !== 1'b0) begin miscompares++; $display("FAIL rd_resp_m_req: got %b want 0", mem_if.req); end
        vectors++; if (inst_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL rd_early_data_ok: got %b want 0", inst_if.data_ok); end
        to_next();
        mem_if.data_ok = 1; mem_if.rdata = 32'hDEADBEEF;
        to_neg();
        vectors++; if (inst_if.data_ok !== 1'b1) begin miscompares++; $display("FAIL rd_i_data_ok: got %b want 1", inst_if.data_ok); end
        vectors++; if (inst_if.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_i_rdata: got %h want deadbeef", inst_if.rdata); end
        vectors++; if (data_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL rd_d_data_ok: got %b want 0", data_if.data_ok); end
        to_next();
        idle_inputs();
        to_neg();
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL rd_end_state: got %0d want IDLE", dut.state); end
        to_next();
    endtask

    task automatic test_simultaneous();
        inst_if.req = 1; inst_if.addr = 32'h1C000010;
        data_if.req = 1; data_if.wr = 1; data_if.addr = 32'h80000000;
        data_if.wstrb = 4'hF; data_if.wdata = 32'h11223344;
        to_neg();
        to_next();
        mem_if.addr_ok = 1;
        to_neg();
        vectors++; if (data_if.addr_ok !== 1'b1) begin miscompares++; $display("FAIL sim_d_addr_ok: got %b want 1", data_if.addr_ok); end
        vectors++; if (inst_if.addr_ok !== 1'b0) begin miscompares++; $display("FAIL sim_i_addr_ok: got %b want 0", inst_if.addr_ok); end
        vectors++; if (mem_if.addr !== 32'h80000000) begin miscompares++; $display("FAIL sim_m_addr: got %h want 80000000", mem_if.addr); end
        vectors++; if (mem_if.wr !== 1'b1) begin miscompares++; $display("FAIL sim_m_wr: got %b want 1", mem_if.wr); end
        vectors++; if (mem_if.wstrb !== 4'hF) begin miscompares++; $display("FAIL sim_m_wstrb: got %h want f", mem_if.wstrb); end
        vectors++; if (mem_if.wdata !== 32'h11223344) begin miscompares++; $display("FAIL sim_m_wdata: got %h want 11223344", mem_if.wdata); end
        to_next();
        data_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1;
        to_neg();
        vectors++; if (data_if.data_ok !== 1'b1) begin miscompares++; $display("FAIL sim_d_data_ok: got %b want 1", data_if.data_ok); end
        vectors++; if (inst_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL sim_i_data_ok: got %b want 0", inst_if.data_ok); end
        to_next();
        mem_if.data_ok = 0;
        to_neg();
        vectors++; if (mem_if.req !== 1'b0) begin miscompares++; $display("FAIL sim_idle_m_req: got %b want 0", mem_if.req); end
        to_next();
        mem_if.addr_ok = 1;
        to_neg();
        vectors++; if (mem_if.req !== 1'b1) begin miscompares++; $display("FAIL sim_inst_m_req: got %b want 1", mem_if.req); end
        vectors++; if (mem_if.addr !== 32'h1C000010) begin miscompares++; $display("FAIL sim_inst_m_addr: got %h want 1c000010", mem_if.addr); end
        vectors++; if (inst_if.addr_ok !== 1'b1) begin miscompares++; $display("FAIL sim_inst_addr_ok: got %b want 1", inst_if.addr_ok); end
        to_next();
        inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h00C0FFEE;
        to_neg();
        vectors++; if (inst_if.data_ok !== 1'b1) begin miscompares++; $display("FAIL sim_inst_data_ok: got %b want 1", inst_if.data_ok); end
        vectors++; if (inst_if.rdata !== 32'h00C0FFEE) begin miscompares++; $display("FAIL sim_inst_rdata: got %h want 00c0ffee", inst_if.rdata); end
        to_next();
        idle_inputs();
        to_next();
    endtask

    task automatic test_starvation();
        int nd = 0;
        bit got = 0;
        inst_if.req = 1; inst_if.addr = 32'h1C000020;
        data_if.req = 1; data_if.addr = 32'h80000100;
        mem_if.addr_ok = 1; mem_if.data_ok = 1;
        for (int c = 0; c < 40 && !got; c++) begin
            to_neg();
            if (data_if.addr_ok) nd++;
            if (inst_if.addr_ok) got = 1;
            to_next();
        end
        inst_if.req = 0; data_if.req = 0; mem_if.addr_ok = 0;
        to_neg();
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL starve_inst_grant: got %b want 1", got); end
        vectors++; if (nd !== 4) begin miscompares++; $display("FAIL starve_data_grants: got %0d want 4", nd); end
        vectors++; if (inst_if.data_ok !== 1'b1) begin miscompares++; $display("FAIL starve_i_data_ok: got %b want 1", inst_if.data_ok); end
        vectors++; if (dut.starve_cnt !== '0) begin miscompares++; $display("FAIL starve_cnt_clr: got %0d want 0", dut.starve_cnt); end
        to_next();
        idle_inputs();
        to_neg();
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL starve_end_state: got %0d want IDLE", dut.state); end
        to_next();
    endtask

    task automatic test_cancel();
        inst_if.req = 1; inst_if.addr = 32'h1C000030;
        to_neg();
        to_next();
        mem_if.addr_ok = 1;
        to_neg();
        vectors++; if (inst_if.addr_ok !== 1'b1) begin miscompares++; $display("FAIL cxl_i_addr_ok: got %b want 1", inst_if.addr_ok); end
        to_next();
        inst_if.req = 0; mem_if.addr_ok = 0; i_cancel = 1;
        to_neg();
        vectors++; if (inst_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL cxl_resp_data_ok: got %b want 0", inst_if.data_ok); end
        to_next();
        i_cancel = 0; mem_if.data_ok = 1; mem_if.rdata = 32'hBAD0BAD0;
        to_neg();
        vectors++; if (inst_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL cxl_i_data_ok: got %b want 0", inst_if.data_ok); end
        vectors++; if (data_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL cxl_d_data_ok: got %b want 0", data_if.data_ok); end
        to_next();
        mem_if.data_ok = 0; data_if.req = 1; data_if.addr = 32'h80000200;
        to_neg();
        vectors++; if (dut.discard !== 1'b0) begin miscompares++; $display("FAIL cxl_discard_clr: got %b want 0", dut.discard); end
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL cxl_state: got %0d want IDLE", dut.state); end
        to_next();
        mem_if.addr_ok = 1;
        to_neg();
        vectors++; if (data_if.addr_ok !== 1'b1) begin miscompares++; $display("FAIL cxl_d_addr_ok: got %b want 1", data_if.addr_ok); end
        vectors++; if (mem_if.addr !== 32'h80000200) begin miscompares++; $display("FAIL cxl_d_m_addr: got %h want 80000200", mem_if.addr); end
        to_next();
        data_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h12345678;
        to_neg();
        vectors++; if (data_if.data_ok !== 1'b1) begin miscompares++; $display("FAIL cxl_d_data_ok2: got %b want 1", data_if.data_ok); end
        vectors++; if (data_if.rdata !== 32'h12345678) begin miscompares++; $display("FAIL cxl_d_rdata: got %h want 12345678", data_if.rdata); end
        to_next();
        idle_inputs();
        // cancel while inst is still waiting for address acceptance
        inst_if.req = 1; inst_if.addr = 32'h1C000040;
        to_neg();
        to_next();
        i_cancel = 1;
        to_neg();
        vectors++; if (inst_if.addr_ok !== 1'b0) begin miscompares++; $display("FAIL abort_i_addr_ok: got %b want 0", inst_if.addr_ok); end
        to_next();
        inst_if.req = 0; i_cancel = 0;
        to_neg();
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL abort_state: got %0d want IDLE", dut.state); end
        vectors++; if (dut.discard !== 1'b0) begin miscompares++; $display("FAIL abort_discard: got %b want 0", dut.discard); end
        to_next();
    endtask

    task automatic test_reset_mid();
        inst_if.req = 1; inst_if.addr = 32'h1C000050;
        to_neg();
        to_next();
        mem_if.addr_ok = 1;
        to_neg();
        to_next();
        inst_if.req = 0; mem_if.addr_ok = 0; rst = 1;
        to_neg();
        vectors++; if (mem_if.req !== 1'b0) begin miscompares++; $display("FAIL rstm_m_req: got %b want 0", mem_if.req); end
        to_next();
        rst = 0;
        to_neg();
        to_next();
        mem_if.data_ok = 1; mem_if.rdata = 32'hFEEDFACE;
        to_neg();
        vectors++; if (inst_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL rstm_i_data_ok: got %b want 0", inst_if.data_ok); end
        vectors++; if (data_if.data_ok !== 1'b0) begin miscompares++; $display("FAIL rstm_d_data_ok: got %b want 0", data_if.data_ok); end
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL rstm_state: got %0d want IDLE", dut.state); end
        to_next();
        idle_inputs();
        to_neg();
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL rstm_state2: got %0d want IDLE", dut.state); end
        to_next();
    endtask

    task automatic test_backpressure();
        data_if.req = 1; data_if.addr = 32'hA0000040;
        to_neg();
        to_next();
        for (int c = 0; c < 10; c++) begin
            to_neg();
            vectors++; if (mem_if.req !== 1'b1) begin miscompares++; $display("FAIL bp_m_req[%0d]: got %b want 1", c, mem_if.req); end
            vectors++; if (mem_if.addr !== 32'hA0000040) begin miscompares++; $display("FAIL bp_m_addr[%0d]: got %h want a0000040", c, mem_if.addr); end
            vectors++; if (data_if.addr_ok !== 1'b0) begin miscompares++; $display("FAIL bp_d_addr_ok[%0d]: got %b want 0", c, data_if.addr_ok); end
            to_next();
        end
        mem_if.addr_ok = 1;
        to_neg();
        vectors++; if (data_if.addr_ok !== 1'b1) begin miscompares++; $display("FAIL bp_d_addr_ok_rise: got %b want 1", data_if.addr_ok); end
        to_next();
        data_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h55AA55AA;
        to_neg();
        vectors++; if (data_if.data_ok !== 1'b1) begin miscompares++; $display("FAIL bp_d_data_ok: got %b want 1", data_if.data_ok); end
        vectors++; if (data_if.rdata !== 32'h55AA55AA) begin miscompares++; $display("FAIL bp_d_rdata: got %h want 55aa55aa", data_if.rdata); end
        to_next();
        idle_inputs();
        // requester withdraws before acceptance; a late addr_ok must be ignored
        data_if.req = 1; data_if.addr = 32'hA0000080;
        to_neg();
        to_next();
        to_neg();
        vectors++; if (mem_if.req !== 1'b1) begin miscompares++; $display("FAIL drop_m_req_on: got %b want 1", mem_if.req); end
        to_next();
        data_if.req = 0; mem_if.addr_ok = 1;
        to_neg();
        vectors++; if (mem_if.req !== 1'b0) begin miscompares++; $display("FAIL drop_m_req_off: got %b want 0", mem_if.req); end
        vectors++; if (data_if.addr_ok !== 1'b0) begin miscompares++; $display("FAIL drop_d_addr_ok: got %b want 0", data_if.addr_ok); end
        to_next();
        mem_if.addr_ok = 0;
        to_neg();
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL drop_state: got %0d want IDLE", dut.state); end
        to_next();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_cancel();
        test_reset_mid();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end
endmodule
